// File: rtl/frogger_pkg.sv
// Shared types and defaults for the Frogger round sequencer: phase encoding,
// default timing constants and the per-level time budget helper.
package frogger_pkg;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_READY     = 3'd1,
    PH_PLAY      = 3'd2,
    PH_DEATH     = 3'd3,
    PH_LEVEL_UP  = 3'd4,
    PH_GAME_OVER = 3'd5,
    PH_VICTORY   = 3'd6,
    PH_PAUSED    = 3'd7
  } phase_t;

  localparam int BASE_TIME  = 60;
  localparam int TIME_STEP  = 5;
  localparam int MIN_TIME   = 20;
  localparam int MSG_FRAMES = 120;

  // Budget shrinks by step per level above 1 and never drops below min_t.
  function automatic logic [7:0] time_budget(input logic [3:0] level,
                                             input int base  = BASE_TIME,
                                             input int step  = TIME_STEP,
                                             input int min_t = MIN_TIME);
    int t;
    t = base - (int'(level) - 1) * step;
    if (t < min_t) t = min_t;
    return 8'(t);
  endfunction

endpackage

// File: rtl/frame_hold_counter.sv
// Banner hold timer shared by the READY, DEATH and LEVEL_UP phases.
// A load pulse on the first frame of a phase makes zero_o rise on its last frame.
module frame_hold_counter
  import frogger_pkg::*;
#(
  parameter int MSG_FRAMES = frogger_pkg::MSG_FRAMES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic zero_o
);

  localparam int CW = ($clog2(MSG_FRAMES) > 8) ? $clog2(MSG_FRAMES) : 8;

  logic [CW-1:0] cnt_q, cnt_d;

  // The load frame itself is the first frame of the hold, hence the -2.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(MSG_FRAMES - 2);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Frogger round sequencer: lives, level, homes, timer control and game phase.
// Optional pause support is built when GAME_FLOW_PAUSE_EN is defined.
module game_flow_ctrl
  import frogger_pkg::*;
#(
  parameter int START_LIVES     = 3,
  parameter int HOMES_PER_LEVEL = 5,
  parameter int BASE_TIME       = frogger_pkg::BASE_TIME,
  parameter int TIME_STEP       = frogger_pkg::TIME_STEP,
  parameter int MIN_TIME        = frogger_pkg::MIN_TIME,
  parameter int MAX_LEVEL       = 9,
  parameter int MSG_FRAMES      = frogger_pkg::MSG_FRAMES
) (
  input  logic       frame_clk,
  input  logic       game_restart,
  input  logic       start_btn,
  input  logic       frog_home,
  input  logic       frog_death,
  input  logic [7:0] timer_value,
`ifdef GAME_FLOW_PAUSE_EN
  input  logic       pause_btn,
`endif
  output logic       timer_load,
  output logic [7:0] timer_load_value,
  output logic       timer_run,
  output logic       frog_respawn,
  output logic [2:0] lives,
  output logic [3:0] level,
  output logic [2:0] homes_filled,
  output logic [2:0] game_phase
);

  phase_t     state_q;
  logic [2:0] lives_q;
  logic [3:0] level_q;
  logic [2:0] homes_q;
  logic       timer_load_q;
  logic       timer_run_q;
  logic       frog_respawn_q;
  logic       hold_load_q;
  logic       start_prev_q;
  logic       hold_zero;
  logic       hold_done;
  logic       timeout;
`ifdef GAME_FLOW_PAUSE_EN
  logic       pause_prev_q;
  logic       pause_rise;
  assign pause_rise = pause_btn && !pause_prev_q;
`endif

  frame_hold_counter #(
    .MSG_FRAMES(MSG_FRAMES)
  ) u_hold (
    .clk_i (frame_clk),
    .rst_i (game_restart),
    .load_i(hold_load_q),
    .zero_o(hold_zero)
  );

  // The counter still shows the previous phase's value during the load frame.
  assign hold_done = hold_zero && !hold_load_q;
  // While the load pulse is out the timer may still hold last round's zero.
  assign timeout   = (timer_value == 8'd0) && !timer_load_q;

  always_ff @(posedge frame_clk) begin
    if (game_restart) begin
      state_q        <= PH_IDLE;
      lives_q        <= 3'(START_LIVES);
      level_q        <= 4'd1;
      homes_q        <= 3'd0;
      timer_load_q   <= 1'b0;
      timer_run_q    <= 1'b0;
      frog_respawn_q <= 1'b0;
      hold_load_q    <= 1'b0;
      start_prev_q   <= 1'b0;
`ifdef GAME_FLOW_PAUSE_EN
      pause_prev_q   <= 1'b0;
`endif
    end else begin
      timer_load_q   <= 1'b0;
      frog_respawn_q <= 1'b0;
      hold_load_q    <= 1'b0;
      start_prev_q   <= start_btn;
`ifdef GAME_FLOW_PAUSE_EN
      pause_prev_q   <= pause_btn;
`endif
      case (state_q)
        PH_IDLE: begin
          if (start_btn) begin
            lives_q     <= 3'(START_LIVES);
            level_q     <= 4'd1;
            homes_q     <= 3'd0;
            hold_load_q <= 1'b1;
            state_q     <= PH_READY;
          end
        end
        PH_READY: begin
          if (hold_done) begin
            timer_load_q   <= 1'b1;
            frog_respawn_q <= 1'b1;
            timer_run_q    <= 1'b1;
            state_q        <= PH_PLAY;
          end
        end
        PH_PLAY: begin
`ifdef GAME_FLOW_PAUSE_EN
          if (pause_rise) begin
            timer_run_q <= 1'b0;
            state_q     <= PH_PAUSED;
          end else
`endif
          if (frog_home) begin
            homes_q <= homes_q + 3'd1;
            if (homes_q + 3'd1 == 3'(HOMES_PER_LEVEL)) begin
              timer_run_q <= 1'b0;
              hold_load_q <= 1'b1;
              state_q     <= PH_LEVEL_UP;
            end else begin
              timer_load_q   <= 1'b1;
              frog_respawn_q <= 1'b1;
            end
          end else if (frog_death || timeout) begin
            if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
            timer_run_q <= 1'b0;
            hold_load_q <= 1'b1;
            state_q     <= PH_DEATH;
          end
        end
        PH_DEATH: begin
          if (hold_done) begin
            if (lives_q == 3'd0) begin
              state_q <= PH_GAME_OVER;
            end else begin
              hold_load_q <= 1'b1;
              state_q     <= PH_READY;
            end
          end
        end
        PH_LEVEL_UP: begin
          if (hold_done) begin
            if (level_q >= 4'(MAX_LEVEL)) begin
              state_q <= PH_VICTORY;
            end else begin
              level_q     <= level_q + 4'd1;
              homes_q     <= 3'd0;
              hold_load_q <= 1'b1;
              state_q     <= PH_READY;
            end
          end
        end
        PH_GAME_OVER, PH_VICTORY: begin
          if (start_btn && !start_prev_q) begin
            lives_q     <= 3'(START_LIVES);
            level_q     <= 4'd1;
            homes_q     <= 3'd0;
            hold_load_q <= 1'b1;
            state_q     <= PH_READY;
          end
        end
        PH_PAUSED: begin
`ifdef GAME_FLOW_PAUSE_EN
          if (pause_rise) begin
            timer_run_q <= 1'b1;
            state_q     <= PH_PLAY;
          end
`else
          state_q <= PH_IDLE;
`endif
        end
        default: state_q <= PH_IDLE;
      endcase
    end
  end

  assign timer_load       = timer_load_q;
  assign timer_load_value = time_budget(level_q, BASE_TIME, TIME_STEP, MIN_TIME);
  assign timer_run        = timer_run_q;
  assign frog_respawn     = frog_respawn_q;
  assign lives            = lives_q;
  assign level            = level_q;
  assign homes_filled     = homes_q;
  assign game_phase       = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: stimulus queues expected snapshots,
// a negedge monitor compares them on every phase change, timer load or probe.
module tb_game_flow_ctrl;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] lives;
    logic [3:0] level;
    logic [2:0] homes;
    logic       load;
    logic [7:0] lv;
    logic       resp;
    logic       run;
  } snap_t;

  logic       frame_clk = 1'b0;
  logic       game_restart = 1'b1;
  logic       start_btn = 1'b0;
  logic       frog_home = 1'b0;
  logic       frog_death = 1'b0;
  logic [7:0] timer_value = 8'd60;
`ifdef GAME_FLOW_PAUSE_EN
  logic       pause_btn = 1'b0;
`endif
  logic       timer_load;
  logic [7:0] timer_load_value;
  logic       timer_run;
  logic       frog_respawn;
  logic [2:0] lives;
  logic [3:0] level;
  logic [2:0] homes_filled;
  logic [2:0] game_phase;

  game_flow_ctrl dut (
    .frame_clk       (frame_clk),
    .game_restart    (game_restart),
    .start_btn       (start_btn),
    .frog_home       (frog_home),
    .frog_death      (frog_death),
    .timer_value     (timer_value),
`ifdef GAME_FLOW_PAUSE_EN
    .pause_btn       (pause_btn),
`endif
    .timer_load      (timer_load),
    .timer_load_value(timer_load_value),
    .timer_run       (timer_run),
    .frog_respawn    (frog_respawn),
    .lives           (lives),
    .level           (level),
    .homes_filled    (homes_filled),
    .game_phase      (game_phase)
  );

  always #5 frame_clk = ~frame_clk;

  snap_t exp_q[$];
  int    age_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    tmo_cnt = 0;
  logic  mon_en = 1'b0;
  logic  probe = 1'b0;
  logic  done_req = 1'b0;
  int    bud [0:9] = '{0, 60, 55, 50, 45, 40, 35, 30, 25, 20};

  // Monitor: sole owner of the compare/fail counters.
  logic [2:0] last_ph;
  int         in_ph;
  always @(negedge frame_clk) begin
    snap_t act, e;
    int    age, ea;
    if (!mon_en) begin
      last_ph = game_phase;
      in_ph   = 0;
    end else begin
      age = -1;
      if (game_phase != last_ph) begin
        age   = in_ph;
        in_ph = 1;
      end else begin
        in_ph++;
      end
      if (game_phase != last_ph || timer_load || probe) begin
        act = '{game_phase, lives, level, homes_filled, timer_load,
                timer_load_value, frog_respawn, timer_run};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got ph=%0d lives=%0d lvl=%0d homes=%0d load=%0d val=%0d resp=%0d run=%0d, required no event",
                   act.ph, act.lives, act.level, act.homes, act.load, act.lv, act.resp, act.run);
        end else begin
          e  = exp_q.pop_front();
          ea = age_q.pop_front();
          if (act !== e || (ea >= 0 && ea != age)) begin
            n_bad++;
            $display("FAIL snapshot#%0d: got ph=%0d lives=%0d lvl=%0d homes=%0d load=%0d val=%0d resp=%0d run=%0d age=%0d, required ph=%0d lives=%0d lvl=%0d homes=%0d load=%0d val=%0d resp=%0d run=%0d age=%0d",
                     n_cmp, act.ph, act.lives, act.level, act.homes, act.load, act.lv, act.resp, act.run, age,
                     e.ph, e.lives, e.level, e.homes, e.load, e.lv, e.resp, e.run, ea);
          end
        end
      end
      last_ph = game_phase;
      if (done_req) begin
        n_cmp++;
        if (exp_q.size() != 0) begin
          n_bad++;
          $display("FAIL drain: got %0d outstanding expected events, required 0", exp_q.size());
        end
        n_cmp++;
        if (tmo_cnt != 0) begin
          n_bad++;
          $display("FAIL phase_waits: got %0d expired waits, required 0", tmo_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic push(input int ph, input int lv_lives, input int lvl, input int hm,
                      input int ld, input int lval, input int rs, input int rn, input int age);
    snap_t s;
    s.ph = 3'(ph); s.lives = 3'(lv_lives); s.level = 4'(lvl); s.homes = 3'(hm);
    s.load = 1'(ld); s.lv = 8'(lval); s.resp = 1'(rs); s.run = 1'(rn);
    exp_q.push_back(s);
    age_q.push_back(age);
  endtask

  task automatic wait_phase(input logic [2:0] p, input int lim);
    int n = 0;
    while (game_phase !== p && n < lim) begin
      @(negedge frame_clk);
      n++;
    end
    if (game_phase !== p) begin
      tmo_cnt++;
      $display("FAIL wait_phase: got phase %0d, required %0d", game_phase, p);
    end
    tick(1);
  endtask

  task automatic pulse_home();
    frog_home = 1'b1; tick(1); frog_home = 1'b0; tick(2);
  endtask

  task automatic pulse_death();
    frog_death = 1'b1; tick(1); frog_death = 1'b0; tick(2);
  endtask

  task automatic do_probe();
    probe = 1'b1; tick(1); probe = 1'b0; tick(1);
  endtask

  initial begin
    tick(3);
    game_restart = 1'b0;
    tick(1);
    mon_en = 1'b1;
    tick(1);

    // reset state
    push(0, 3, 1, 0, 0, 60, 0, 0, -1);
    do_probe();

    // start, 120-frame READY, first load
    push(1, 3, 1, 0, 0, 60, 0, 0, -1);
    push(2, 3, 1, 0, 1, 60, 1, 1, 120);
    start_btn = 1'b1; tick(1); start_btn = 1'b0;
    wait_phase(3'd2, 400);

    // level 1: five homes -> level up -> level 2 at 55 s
    for (int k = 1; k <= 4; k++) begin
      push(2, 3, 1, k, 1, 60, 1, 1, -1);
      pulse_home();
    end
    push(4, 3, 1, 5, 0, 60, 0, 0, -1);
    push(1, 3, 2, 0, 0, 55, 0, 0, 120);
    push(2, 3, 2, 0, 1, 55, 1, 1, 120);
    pulse_home();
    wait_phase(3'd2, 400);

    // two homes, then home and death together: home wins
    push(2, 3, 2, 1, 1, 55, 1, 1, -1); pulse_home();
    push(2, 3, 2, 2, 1, 55, 1, 1, -1); pulse_home();
    push(2, 3, 2, 3, 1, 55, 1, 1, -1);
    frog_home = 1'b1; frog_death = 1'b1; tick(1);
    frog_home = 1'b0; frog_death = 1'b0; tick(2);

    // timeout -> death, homes kept
    push(3, 2, 2, 3, 0, 55, 0, 0, -1);
    push(1, 2, 2, 3, 0, 55, 0, 0, 120);
    push(2, 2, 2, 3, 1, 55, 1, 1, 120);
    timer_value = 8'd0; tick(1); timer_value = 8'd60;
    wait_phase(3'd2, 400);

`ifdef GAME_FLOW_PAUSE_EN
    push(7, 2, 2, 3, 0, 55, 0, 0, -1);
    pause_btn = 1'b1; tick(1); pause_btn = 1'b0; tick(2);
    pulse_death();
    push(7, 2, 2, 3, 0, 55, 0, 0, -1);
    do_probe();
    push(2, 2, 2, 3, 0, 55, 0, 1, -1);
    pause_btn = 1'b1; tick(1); pause_btn = 1'b0; tick(2);
`endif

    // two more deaths -> game over
    push(3, 1, 2, 3, 0, 55, 0, 0, -1);
    push(1, 1, 2, 3, 0, 55, 0, 0, 120);
    push(2, 1, 2, 3, 1, 55, 1, 1, 120);
    pulse_death();
    wait_phase(3'd2, 400);
    push(3, 0, 2, 3, 0, 55, 0, 0, -1);
    push(5, 0, 2, 3, 0, 55, 0, 0, 120);
    pulse_death();
    wait_phase(3'd5, 400);
    tick(3);
    pulse_home();
    push(5, 0, 2, 3, 0, 55, 0, 0, -1);
    do_probe();

    // start edge from game over, then restart mid-DEATH hold
    push(1, 3, 1, 0, 0, 60, 0, 0, -1);
    push(2, 3, 1, 0, 1, 60, 1, 1, 120);
    start_btn = 1'b1; tick(1); start_btn = 1'b0;
    wait_phase(3'd2, 400);
    push(3, 2, 1, 0, 0, 60, 0, 0, -1);
    pulse_death();
    tick(10);
    push(0, 3, 1, 0, 0, 60, 0, 0, -1);
    game_restart = 1'b1; tick(1); game_restart = 1'b0;
    tick(3);

    // full run to victory; events in READY are ignored
    push(1, 3, 1, 0, 0, 60, 0, 0, -1);
    start_btn = 1'b1; tick(1); start_btn = 1'b0;
    tick(5);
    pulse_death();
    pulse_home();
    for (int lv = 1; lv <= 9; lv++) begin
      push(2, 3, lv, 0, 1, bud[lv], 1, 1, 120);
      wait_phase(3'd2, 400);
      for (int k = 1; k <= 4; k++) begin
        push(2, 3, lv, k, 1, bud[lv], 1, 1, -1);
        pulse_home();
      end
      push(4, 3, lv, 5, 0, bud[lv], 0, 0, -1);
      if (lv < 9) push(1, 3, lv + 1, 0, 0, bud[lv + 1], 0, 0, 120);
      else        push(6, 3, 9, 5, 0, 20, 0, 0, 120);
      pulse_home();
    end
    wait_phase(3'd6, 400);
    pulse_home();
    pulse_death();
    push(6, 3, 9, 5, 0, 20, 0, 0, -1);
    do_probe();

    tick(3);
    done_req = 1'b1;
    tick(5);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level round sequencer for Frogger. Drives the per-second countdown timer block via load, value and run controls, and consumes its 8-bit time output.
- Tracks lives, level and filled homes. Decides death, level-up, game-over and victory.
- Sits between the frog/collision logic (event pulses) and the timer/HUD/sprite logic. All logic runs on the frame clock.

Parameters:
- START_LIVES, 3, lives at game start (1..7).
- HOMES_PER_LEVEL, 5, homes to fill to clear a level (1..7).
- BASE_TIME, 60, level-1 time budget in seconds.
- TIME_STEP, 5, seconds removed per level above 1.
- MIN_TIME, 20, floor on time budget.
- MAX_LEVEL, 9, clearing this level gives VICTORY (1..15).
- MSG_FRAMES, 120, banner hold length in frames for READY, DEATH and LEVEL_UP.

Ports:
- frame_clk  in  1  frame clock; only clock.
- game_restart  in  1  synchronous, active-high reset.
- start_btn  in  1  level-sensitive start request.
- frog_home  in  1  one-frame pulse: frog reached an empty home.
- frog_death  in  1  one-frame pulse: collision or drowning.
- timer_value  in  8  current countdown seconds from the timer.
- timer_load  out  1  one-frame pulse: timer loads timer_load_value.
- timer_load_value  out  8  current level's time budget.
- timer_run  out  1  timer may decrement; high only in PLAY.
- frog_respawn  out  1  one-frame pulse: place frog at start row.
- lives  out  3  remaining lives.
- level  out  4  current level, 1-based.
- homes_filled  out  3  homes filled this level.
- game_phase  out  3  encoded FSM state for HUD/banner logic.

Behaviour:
- Reset: sampled on the frame_clk edge only; no asynchronous path. Reset wins over every event, including mid-DEATH and mid-hold.
- Reset values: state IDLE; lives=START_LIVES; level=1; homes_filled=0; hold=0; timer_load=0; timer_run=0; frog_respawn=0.
- Time budget: BASE_TIME-(level-1)*TIME_STEP, computed at 9 bits, clamped to MIN_TIME. timer_load_value is combinational from level. Example: level 1→60, level 8→25, level 9→20.
- IDLE: start_btn=1 → READY. lives, level and homes_filled are re-initialised on this transition.
- READY: hold counter counts MSG_FRAMES frames. On the final frame: timer_load=1, frog_respawn=1 (same cycle), next state PLAY.
- PLAY: timer_run=1. Event priority, highest first:
  - frog_home: homes_filled+1. If the result equals HOMES_PER_LEVEL → LEVEL_UP; otherwise stay in PLAY, pulse frog_respawn and timer_load (budget refills per frog).
  - frog_death → DEATH.
  - timer_value==0 (timeout) → DEATH.
- Simultaneous frog_home and frog_death/timeout in one frame: home wins, death is dropped.
- DEATH: lives decrements once, on entry. Hold MSG_FRAMES frames, then:
  - lives==0 → GAME_OVER;
  - else → READY. homes_filled is kept.
- LEVEL_UP: hold MSG_FRAMES frames, then:
  - level==MAX_LEVEL → VICTORY;
  - else level+1, homes_filled=0, → READY.
- GAME_OVER and VICTORY: terminal. start_btn rising edge (registered previous value) → IDLE path: re-initialise, go to READY.
- frog_home and frog_death are ignored in every state other than PLAY.
- Counter widths: level saturates at MAX_LEVEL; lives never underflows; hold counter is 8 bits minimum (sized from MSG_FRAMES).
- Outputs are registered (Moore) except timer_load_value. All pulses last exactly one frame.
- game_phase encoding: IDLE=0, READY=1, PLAY=2, DEATH=3, LEVEL_UP=4, GAME_OVER=5, VICTORY=6, PAUSED=7.

Optional Feature:
- Macro: GAME_FLOW_PAUSE_EN.
- Defined: adds port pause_btn (in, 1). In PLAY, a pause_btn rising edge → PAUSED with timer_run=0 and all events ignored. The next rising edge → PLAY. Pause does not change timer_value.
- Undefined: no port, PAUSED is unreachable, game_phase never equals 7.

Decomposition:
- Package frogger_pkg holds:
  - phase_t enum (3-bit, encodings above);
  - default constants BASE_TIME, TIME_STEP, MIN_TIME, MSG_FRAMES;
  - function time_budget(level) returning 8 bits.
- One sub-module, frame_hold_counter: load, count and done flag, parameterised by MSG_FRAMES. It is shared by READY, DEATH and LEVEL_UP.

Test Plan:
- Reset then start_btn: after 120 frames → one frame with timer_load=1, timer_load_value=60, frog_respawn=1; then game_phase=2, timer_run=1.
- Five frog_home pulses in level 1 → LEVEL_UP; after 120 frames level=2, homes_filled=0; at the next load timer_load_value=55.
- timer_value=0 in PLAY with lives=3 → DEATH, lives=2; after the hold → READY, homes_filled unchanged.
- frog_home and frog_death in the same frame with homes_filled=2 → homes_filled=3, lives unchanged, stays in PLAY.
- Three deaths → GAME_OVER (phase 5), timer_run=0. game_restart during the DEATH hold → IDLE next edge with lives=3.
- Force level=9 with 4 homes filled, one frog_home → LEVEL_UP then VICTORY (phase 6). With GAME_FLOW_PAUSE_EN defined, a pause_btn edge in PLAY → phase 7, timer_run=0, frog_death ignored.
